mem_io_sequencer: RTL and testbench
===================================

// Module: mem_io_sequencer
// PURPOSE
//  Parametrised operator front-end between push-button/switch inputs and the memory controller.
//  Operators select a mode, then enter the address and write data in switch-sized chunks.
//  The block issues a request and waits for completion, with a timeout.
//  Results are presented on a display bus.
//  New in this generation:
//   - generic address, data and switch widths
//   - a burst-read mode with address auto-increment
//   - a one-cycle request strobe
//   - a completion timeout with an error state
// PARAMETERS
//  ADDR_W   25    memory address width
//  DATA_W   16    memory data width
//  SW_W     9     switch bus width (>=3)
//  TIMEOUT  1024  max cycles in WAIT before ERROR (>=2)
//  Derived:
//   - CH = SW_W-1: chunk width for every chunk except the last
//   - NA = ceil((ADDR_W-1)/CH) address chunks
//   - ND = ceil((DATA_W-1)/CH) data chunks
//   - The final chunk takes all remaining bits; this must be <= SW_W (elaboration assert)
// PORTS
//  clk            in   1         single clock; all logic on posedge
//  rst            in   1         asynchronous, active-high reset
//  key0_pulse     in   1         one-cycle pulse: select mode / abort / return
//  key1_pulse     in   1         one-cycle pulse: latch chunk / confirm / next burst
//  sw             in   SW_W      operator switches
//  memDone        in   1         controller status; low while busy, high when idle/complete
//  read_data      in   DATA_W    controller read data, valid when memDone rises
//  memReq         out  1         one-cycle request strobe
//  modeOutput     out  2         00 read, 01 write; held stable from memReq until WAIT exits
//  memoryAddress  out  ADDR_W    assembled address
//  write_data     out  DATA_W    assembled write data
//  displayData    out  DATA_W    value shown to operator
//  ioDone         out  1         high (level) while in DONE
//  errFlag        out  1         high (level) while in ERROR
//  out_state      out  4         encoded current state, for debug
// BEHAVIOUR
//  Reset: all outputs 0 and out_state=IDLE(0), asynchronously.
//   - Any in-flight request is dropped; memReq never pulses during or in the cycle after reset.
//  States (codes):
//   IDLE=0, SEL=1, ADDR=2, DATA=3, ISSUE=4, WAIT=5, DONE=6, ERROR=7.
//   Chunk index k is a separate counter, 0..NA-1 or 0..ND-1.
//  IDLE: key0_pulse -> SEL.
//  SEL: key1_pulse latches mode from sw[1:0]:
//   - 00 read, 01 write, 10 burst-read (drives modeOutput=00)
//   - 11 invalid: stay in SEL
//   - Valid mode -> ADDR with k=0
//  ADDR: key1_pulse writes chunk k of memoryAddress from sw; k++ after each write.
//   - Chunk k occupies bits [k*CH +: CH]; the last chunk takes the remaining upper bits from sw.
//   - Other bits are unchanged.
//   - After the last chunk: write mode -> DATA with k=0; otherwise -> ISSUE.
//  DATA: same chunk rules applied to write_data; after the last chunk -> ISSUE.
//  ISSUE: memReq=1 for exactly this one cycle; clear the timeout counter; -> WAIT.
//  WAIT:
//   - Completion = memDone sampled 0 then 1 within WAIT, i.e. a rising edge.
//     A memDone that stays high from ISSUE onward is not completion.
//   - Read completion: capture read_data into displayData -> DONE.
//   - Write completion: displayData = write_data -> DONE.
//   - Counter reaches TIMEOUT-1 with no completion -> ERROR.
//   - key0/key1 pulses are ignored in WAIT.
//  DONE:
//   - key0_pulse -> IDLE.
//   - In burst mode, key1_pulse increments memoryAddress by 1, then -> ISSUE.
//     The increment is modulo 2^ADDR_W; all-ones wraps to 0.
//   - key1_pulse outside burst mode is ignored.
//  ERROR: key0_pulse -> IDLE, which clears errFlag; other inputs are ignored.
//  Abort: key0_pulse in SEL, ADDR or DATA -> IDLE. Partially entered chunks keep their values.
//  Simultaneous key0_pulse and key1_pulse: key0 wins in every state.
//  displayData outside DONE shows sw zero-extended to DATA_W.
//  Latency: ISSUE is 1 cycle after the final key1_pulse; DONE is 1 cycle after the memDone rise.
// TESTING
//  1. Read: key0; sw=00,key1; then sw=0FF,0FF,1FF with key1 each; memDone 1->0->1 with read_data=AAAA.
//     -> memoryAddress=1FFFFFF; one memReq pulse; modeOutput=00.
//     -> displayData=AAAA and ioDone=1; a later key0 -> IDLE.
//  2. Write: mode 01; address 034,012,001; data 0CD,0AB; memDone pulse low.
//     -> memoryAddress=0011234, write_data=ABCD, modeOutput=01, displayData=ABCD.
//  3. Burst from address 1FFFFFF: complete, key1, complete.
//     -> second memReq carries memoryAddress=0000000 (wrap); two DONE visits.
//  4. Hold memDone=1 after ISSUE for TIMEOUT cycles -> ERROR, errFlag=1, ioDone=0; key0 -> IDLE.
//  5. key0 and key1 in the same cycle in ADDR at k=1 -> IDLE, and no memReq.
//     Assert rst during WAIT -> all outputs 0 immediately.
//  6. sw[1:0]=11 in SEL -> stays SEL (out_state=1); invalid mode is never latched.

Source files
------------

// File: rtl/mem_io_sequencer.sv
// mem_io_sequencer
//   Operator front-end between push-button/switch inputs and a memory controller.
//   The operator picks a mode (read, write, burst-read), keys in the address and
//   optionally write data in switch-sized chunks, then the block issues a one-cycle
//   request and waits for the controller to complete, with a timeout.
//
// Ports
//   clk            in   1       clock, all logic on posedge
//   rst            in   1       asynchronous active-high reset
//   key0_pulse     in   1       select mode / abort / return to idle
//   key1_pulse     in   1       latch chunk / confirm mode / next burst beat
//   sw             in   SW_W    operator switches
//   memDone        in   1       controller idle/complete (low while busy)
//   read_data      in   DATA_W  controller read data, valid on memDone rise
//   memReq         out  1       one-cycle request strobe
//   modeOutput     out  2       00 read, 01 write
//   memoryAddress  out  ADDR_W  assembled address
//   write_data     out  DATA_W  assembled write data
//   displayData    out  DATA_W  operator display
//   ioDone         out  1       high while in DONE
//   errFlag        out  1       high while in ERROR
//   out_state      out  4       current state code
module mem_io_sequencer #(
    parameter int unsigned ADDR_W  = 25,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned SW_W    = 9,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              key0_pulse,
    input  logic              key1_pulse,
    input  logic [SW_W-1:0]   sw,
    input  logic              memDone,
    input  logic [DATA_W-1:0] read_data,
    output logic              memReq,
    output logic [1:0]        modeOutput,
    output logic [ADDR_W-1:0] memoryAddress,
    output logic [DATA_W-1:0] write_data,
    output logic [DATA_W-1:0] displayData,
    output logic              ioDone,
    output logic              errFlag,
    output logic [3:0]        out_state
);

    localparam int unsigned CH    = SW_W - 1;
    localparam int unsigned NA    = (ADDR_W + CH - 2) / CH;
    localparam int unsigned ND    = (DATA_W + CH - 2) / CH;
    // Width of the final chunk, which takes all remaining upper bits.
    localparam int unsigned ALAST = ADDR_W - (NA - 1) * CH;
    localparam int unsigned DLAST = DATA_W - (ND - 1) * CH;
    localparam int unsigned KMAX  = (NA > ND) ? NA : ND;
    localparam int unsigned KW    = (KMAX > 1) ? $clog2(KMAX) : 1;
    localparam int unsigned TW    = $clog2(TIMEOUT);

    if (SW_W < 3) begin : g_bad_sw
        $error("SW_W must be at least 3");
    end
    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("TIMEOUT must be at least 2");
    end
    if (ALAST > SW_W || DLAST > SW_W) begin : g_bad_last_chunk
        $error("final chunk is wider than the switch bus");
    end

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StSel   = 3'd1,
        StAddr  = 3'd2,
        StData  = 3'd3,
        StIssue = 3'd4,
        StWait  = 3'd5,
        StDone  = 3'd6,
        StError = 3'd7
    } state_e;

    typedef enum logic [1:0] {
        ModeRead  = 2'b00,
        ModeWrite = 2'b01,
        ModeBurst = 2'b10
    } mode_e;

    state_e            state_q, state_d;
    mode_e             mode_q, mode_d;
    logic [KW-1:0]     k_q, k_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] disp_q, disp_d;
    logic [TW-1:0]     cnt_q, cnt_d;
    // Set once memDone has been seen low in WAIT; a later high is a completion.
    logic              seen_low_q, seen_low_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            mode_q     <= ModeRead;
            k_q        <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            disp_q     <= '0;
            cnt_q      <= '0;
            seen_low_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            k_q        <= k_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            disp_q     <= disp_d;
            cnt_q      <= cnt_d;
            seen_low_q <= seen_low_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        k_d        = k_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        disp_d     = disp_q;
        cnt_d      = cnt_q;
        seen_low_d = seen_low_q;

        case (state_q)
            StIdle: begin
                if (key0_pulse) state_d = StSel;
            end
            StSel: begin
                if (key0_pulse) begin
                    state_d = StIdle;
                end else if (key1_pulse && sw[1:0] != 2'b11) begin
                    mode_d  = mode_e'(sw[1:0]);
                    k_d     = '0;
                    state_d = StAddr;
                end
            end
            StAddr: begin
                if (key0_pulse) begin
                    state_d = StIdle;
                end else if (key1_pulse) begin
                    if (k_q == KW'(NA - 1)) begin
                        addr_d[ADDR_W-1 -: ALAST] = sw[ALAST-1:0];
                        k_d     = '0;
                        state_d = (mode_q == ModeWrite) ? StData : StIssue;
                    end else begin
                        addr_d[k_q*CH +: CH] = sw[CH-1:0];
                        k_d = k_q + KW'(1);
                    end
                end
            end
            StData: begin
                if (key0_pulse) begin
                    state_d = StIdle;
                end else if (key1_pulse) begin
                    if (k_q == KW'(ND - 1)) begin
                        wdata_d[DATA_W-1 -: DLAST] = sw[DLAST-1:0];
                        k_d     = '0;
                        state_d = StIssue;
                    end else begin
                        wdata_d[k_q*CH +: CH] = sw[CH-1:0];
                        k_d = k_q + KW'(1);
                    end
                end
            end
            StIssue: begin
                cnt_d      = '0;
                seen_low_d = 1'b0;
                state_d    = StWait;
            end
            StWait: begin
                if (seen_low_q && memDone) begin
                    disp_d  = (mode_q == ModeWrite) ? wdata_q : read_data;
                    state_d = StDone;
                end else if (cnt_q == TW'(TIMEOUT - 1)) begin
                    state_d = StError;
                end else begin
                    cnt_d = cnt_q + TW'(1);
                    if (!memDone) seen_low_d = 1'b1;
                end
            end
            StDone: begin
                if (key0_pulse) begin
                    state_d = StIdle;
                end else if (key1_pulse && mode_q == ModeBurst) begin
                    addr_d  = addr_q + ADDR_W'(1);
                    state_d = StIssue;
                end
            end
            StError: begin
                if (key0_pulse) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign memReq        = (state_q == StIssue);
    // Burst reads look like plain reads to the controller.
    assign modeOutput    = (mode_q == ModeWrite) ? 2'b01 : 2'b00;
    assign memoryAddress = addr_q;
    assign write_data    = wdata_q;
    assign ioDone        = (state_q == StDone);
    assign errFlag       = (state_q == StError);
    assign out_state     = {1'b0, state_q};
    // Gated by rst so the switch pass-through does not show during reset.
    assign displayData   = rst ? '0 : ((state_q == StDone) ? disp_q : DATA_W'(sw));

endmodule

// File: tb/tb_mem_io_sequencer.sv
module tb_mem_io_sequencer;

    localparam int unsigned ADDR_W  = 25;
    localparam int unsigned DATA_W  = 16;
    localparam int unsigned SW_W    = 9;
    localparam int unsigned TIMEOUT = 1024;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              key0_pulse = 1'b0;
    logic              key1_pulse = 1'b0;
    logic [SW_W-1:0]   sw = '0;
    logic              memDone = 1'b1;
    logic [DATA_W-1:0] read_data = '0;
    logic              memReq;
    logic [1:0]        modeOutput;
    logic [ADDR_W-1:0] memoryAddress;
    logic [DATA_W-1:0] write_data;
    logic [DATA_W-1:0] displayData;
    logic              ioDone;
    logic              errFlag;
    logic [3:0]        out_state;

    int checks = 0;
    int errors = 0;
    int req_cnt = 0;
    int req_base;

    mem_io_sequencer #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .SW_W   (SW_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .key0_pulse   (key0_pulse),
        .key1_pulse   (key1_pulse),
        .sw           (sw),
        .memDone      (memDone),
        .read_data    (read_data),
        .memReq       (memReq),
        .modeOutput   (modeOutput),
        .memoryAddress(memoryAddress),
        .write_data   (write_data),
        .displayData  (displayData),
        .ioDone       (ioDone),
        .errFlag      (errFlag),
        .out_state    (out_state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (memReq) req_cnt <= req_cnt + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press0();
        key0_pulse = 1'b1;
        tick();
        key0_pulse = 1'b0;
    endtask

    task automatic press1(input logic [SW_W-1:0] v);
        sw = v;
        key1_pulse = 1'b1;
        tick();
        key1_pulse = 1'b0;
    endtask

    // memDone low for one cycle then high: one rising edge inside WAIT.
    task automatic complete_mem(input logic [DATA_W-1:0] rd);
        read_data = rd;
        memDone = 1'b0;
        tick();
        memDone = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        sw = 9'h1FF;
        tick();
        tick();
        checks++;
        if (out_state !== 4'd0) begin
            errors++; $display("FAIL reset_state: got %0d expected 0", out_state);
        end
        checks++;
        if ({memReq, modeOutput, memoryAddress, write_data, displayData, ioDone, errFlag} !== '0)
        begin
            errors++;
            $display("FAIL reset_outputs: got req=%b mode=%b addr=%h wd=%h disp=%h done=%b err=%b expected all 0",
                     memReq, modeOutput, memoryAddress, write_data, displayData, ioDone, errFlag);
        end
        rst = 1'b0;
        sw = '0;
        tick();
    endtask

    task automatic test_read();
        req_base = req_cnt;
        sw = 9'h1A5;
        #1;
        checks++;
        if (displayData !== 16'h01A5) begin
            errors++; $display("FAIL idle_display_sw: got %h expected 01a5", displayData);
        end
        press0();
        checks++;
        if (out_state !== 4'd1) begin
            errors++; $display("FAIL read_sel: got %0d expected 1", out_state);
        end
        press1(9'h000);
        checks++;
        if (out_state !== 4'd2) begin
            errors++; $display("FAIL read_addr_state: got %0d expected 2", out_state);
        end
        press1(9'h0FF);
        press1(9'h0FF);
        press1(9'h1FF);
        checks++;
        if (out_state !== 4'd4 || memReq !== 1'b1) begin
            errors++; $display("FAIL read_issue: got state=%0d req=%b expected 4/1", out_state, memReq);
        end
        checks++;
        if (memoryAddress !== 25'h1FFFFFF || modeOutput !== 2'b00) begin
            errors++;
            $display("FAIL read_addr: got addr=%h mode=%b expected 1ffffff/00", memoryAddress, modeOutput);
        end
        tick();
        tick();
        tick();
        checks++;
        if (out_state !== 4'd5 || memReq !== 1'b0) begin
            errors++; $display("FAIL read_wait_high: got state=%0d req=%b expected 5/0", out_state, memReq);
        end
        complete_mem(16'hAAAA);
        checks++;
        if (out_state !== 4'd6 || ioDone !== 1'b1 || displayData !== 16'hAAAA) begin
            errors++;
            $display("FAIL read_done: got state=%0d done=%b disp=%h expected 6/1/aaaa",
                     out_state, ioDone, displayData);
        end
        checks++;
        if (req_cnt - req_base !== 1) begin
            errors++; $display("FAIL read_req_count: got %0d expected 1", req_cnt - req_base);
        end
        press1(9'h000);
        checks++;
        if (out_state !== 4'd6) begin
            errors++; $display("FAIL read_key1_ignored: got %0d expected 6", out_state);
        end
        press0();
        checks++;
        if (out_state !== 4'd0 || ioDone !== 1'b0) begin
            errors++; $display("FAIL read_return: got state=%0d done=%b expected 0/0", out_state, ioDone);
        end
    endtask

    task automatic test_write();
        press0();
        press1(9'h001);
        press1(9'h034);
        press1(9'h012);
        press1(9'h001);
        checks++;
        if (out_state !== 4'd3 || memoryAddress !== 25'h0011234) begin
            errors++;
            $display("FAIL write_addr: got state=%0d addr=%h expected 3/0011234", out_state, memoryAddress);
        end
        press1(9'h0CD);
        press1(9'h0AB);
        checks++;
        if (out_state !== 4'd4 || write_data !== 16'hABCD || modeOutput !== 2'b01) begin
            errors++;
            $display("FAIL write_issue: got state=%0d wd=%h mode=%b expected 4/abcd/01",
                     out_state, write_data, modeOutput);
        end
        tick();
        complete_mem(16'h5555);
        checks++;
        if (out_state !== 4'd6 || displayData !== 16'hABCD || modeOutput !== 2'b01) begin
            errors++;
            $display("FAIL write_done: got state=%0d disp=%h mode=%b expected 6/abcd/01",
                     out_state, displayData, modeOutput);
        end
        press0();
    endtask

    task automatic test_burst();
        req_base = req_cnt;
        press0();
        press1(9'h002);
        press1(9'h0FF);
        press1(9'h0FF);
        press1(9'h1FF);
        checks++;
        if (out_state !== 4'd4 || modeOutput !== 2'b00 || memoryAddress !== 25'h1FFFFFF) begin
            errors++;
            $display("FAIL burst_issue1: got state=%0d mode=%b addr=%h expected 4/00/1ffffff",
                     out_state, modeOutput, memoryAddress);
        end
        tick();
        complete_mem(16'h1111);
        checks++;
        if (out_state !== 4'd6 || displayData !== 16'h1111) begin
            errors++; $display("FAIL burst_done1: got state=%0d disp=%h expected 6/1111", out_state, displayData);
        end
        press1(9'h000);
        checks++;
        if (out_state !== 4'd4 || memReq !== 1'b1 || memoryAddress !== 25'h0000000) begin
            errors++;
            $display("FAIL burst_wrap: got state=%0d req=%b addr=%h expected 4/1/0000000",
                     out_state, memReq, memoryAddress);
        end
        tick();
        complete_mem(16'h2222);
        checks++;
        if (out_state !== 4'd6 || displayData !== 16'h2222 || req_cnt - req_base !== 2) begin
            errors++;
            $display("FAIL burst_done2: got state=%0d disp=%h reqs=%0d expected 6/2222/2",
                     out_state, displayData, req_cnt - req_base);
        end
        press0();
    endtask

    task automatic test_timeout();
        press0();
        press1(9'h000);
        press1(9'h000);
        press1(9'h000);
        press1(9'h000);
        memDone = 1'b1;
        tick();
        key0_pulse = 1'b1;
        key1_pulse = 1'b1;
        tick();
        key0_pulse = 1'b0;
        key1_pulse = 1'b0;
        for (int i = 0; i < int'(TIMEOUT) - 2; i++) tick();
        checks++;
        if (out_state !== 4'd5) begin
            errors++; $display("FAIL timeout_early: got %0d expected 5", out_state);
        end
        tick();
        checks++;
        if (out_state !== 4'd7 || errFlag !== 1'b1 || ioDone !== 1'b0) begin
            errors++;
            $display("FAIL timeout_error: got state=%0d err=%b done=%b expected 7/1/0",
                     out_state, errFlag, ioDone);
        end
        press1(9'h000);
        checks++;
        if (out_state !== 4'd7) begin
            errors++; $display("FAIL error_key1_ignored: got %0d expected 7", out_state);
        end
        press0();
        checks++;
        if (out_state !== 4'd0 || errFlag !== 1'b0) begin
            errors++; $display("FAIL error_clear: got state=%0d err=%b expected 0/0", out_state, errFlag);
        end
    endtask

    task automatic test_abort();
        req_base = req_cnt;
        press0();
        press1(9'h000);
        press1(9'h055);
        sw = 9'h077;
        key0_pulse = 1'b1;
        key1_pulse = 1'b1;
        tick();
        key0_pulse = 1'b0;
        key1_pulse = 1'b0;
        tick();
        tick();
        checks++;
        if (out_state !== 4'd0 || memoryAddress !== 25'h0000055) begin
            errors++;
            $display("FAIL abort: got state=%0d addr=%h expected 0/0000055", out_state, memoryAddress);
        end
        checks++;
        if (req_cnt - req_base !== 0) begin
            errors++; $display("FAIL abort_no_req: got %0d expected 0", req_cnt - req_base);
        end
    endtask

    task automatic test_invalid_mode();
        press0();
        press1(9'h003);
        checks++;
        if (out_state !== 4'd1 || modeOutput !== 2'b00) begin
            errors++;
            $display("FAIL invalid_mode: got state=%0d mode=%b expected 1/00", out_state, modeOutput);
        end
        press1(9'h001);
        checks++;
        if (out_state !== 4'd2 || modeOutput !== 2'b01) begin
            errors++;
            $display("FAIL valid_after_invalid: got state=%0d mode=%b expected 2/01", out_state, modeOutput);
        end
        press0();
    endtask

    task automatic test_reset_in_wait();
        press0();
        press1(9'h000);
        press1(9'h012);
        press1(9'h034);
        press1(9'h001);
        tick();
        checks++;
        if (out_state !== 4'd5) begin
            errors++; $display("FAIL rst_setup_wait: got %0d expected 5", out_state);
        end
        req_base = req_cnt;
        sw = 9'h1FF;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (out_state !== 4'd0 ||
            {memReq, modeOutput, memoryAddress, write_data, displayData, ioDone, errFlag} !== '0)
        begin
            errors++;
            $display("FAIL rst_async: got state=%0d addr=%h wd=%h disp=%h mode=%b expected all 0",
                     out_state, memoryAddress, write_data, displayData, modeOutput);
        end
        tick();
        tick();
        rst = 1'b0;
        tick();
        tick();
        checks++;
        if (req_cnt - req_base !== 0 || out_state !== 4'd0) begin
            errors++;
            $display("FAIL rst_no_req: got reqs=%0d state=%0d expected 0/0", req_cnt - req_base, out_state);
        end
        sw = '0;
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_burst();
        test_timeout();
        test_abort();
        test_invalid_mode();
        test_reset_in_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
